seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
Reader end of the multiplexed 4-digit seven-segment interface that the stopwatch display driver produces. It samples anode_vec/cathode_vec, waits for each anode/cathode pair to settle, decodes the active-low segment pattern back to a BCD digit per position, and assembles complete frames into minutes/seconds values. It serves as a loopback checker on the board and as the scoreboard front end in display testbenches.

Parameters:
SETTLE_CYCLES, 4, consecutive clk cycles a synced {anode,cathode} pair must hold unchanged before capture (min 2)
TIMEOUT_CYCLES, 1048576, clk cycles without any capture before the stale flag is raised
TO_W, 21, timeout counter width, must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
anode_vec  input  4  active-low digit enables; [3]=min tens, [2]=min ones, [1]=sec tens, [0]=sec ones
cathode_vec  input  7  active-low segments; bit0=a, bit1=b … bit6=g
digits  output  16  last captured BCD per position, {d3,d2,d1,d0}
blank  output  4  per position: last capture had all segments off
invalid  output  4  per position: last capture was a non-digit, non-blank pattern
minutes  output  6  decoded minutes from the last valid frame
seconds  output  6  decoded seconds from the last valid frame
frame_strobe  output  1  one-cycle pulse when a frame completes
frame_valid  output  1  registered quality of the most recent frame
stale  output  1  no capture for TIMEOUT_CYCLES

Behaviour:
- Reset (rst=0, async): digits=0, blank=4'hF, invalid=0, minutes=0, seconds=0, frame_strobe=0, frame_valid=0, stale=0, seen mask=0, settle counter=0, timeout counter=0, synchronizers=all-ones.
- Input sync: two-flop synchronizer on all 11 inputs; all further logic uses synced values (2-cycle latency).
- Settle: compare synced pair with the previous cycle's synced pair; any difference clears the counter and the armed flag. Counter saturates. A capture fires in the cycle the pair has been unchanged for SETTLE_CYCLES cycles, and only once per stable pair until the pair changes.
- Capture is legal only if exactly one anode bit is 0. All-high (blink-off/idle) and multiple-low pairs never capture.
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 (bits g..a). 1111111 gives blank=1 and digit=0. Any other pattern gives invalid=1 and digit=0. A capture updates only the addressed position's digit/blank/invalid bits.
- Frame: capture sets seen[pos]. The cycle after seen reaches 4'b1111: frame_strobe=1 for one cycle, seen cleared, stale cleared.
  - frame_valid = no blank, no invalid, d3<=5, d1<=5.
  - If valid: minutes=d3*10+d2 and seconds=d1*10+d0 (6-bit, max 59). Otherwise minutes/seconds hold their previous values.
- Timeout: the counter clears on every capture and otherwise increments. On reaching TIMEOUT_CYCLES: stale=1, seen cleared, counter holds. If a capture occurs in the same cycle as the terminal count, the capture wins (no stale, counter cleared).
- Recapturing an already-seen position before the frame completes overwrites its digit; seen is unchanged.
- Reset mid-frame discards partial frame state immediately.

Test Plan:
- Scan 12:34 (anode 0111/cath 1111001, 1011/0100100, 1101/0110000, 1110/0011001), 10 cycles per digit -> single frame_strobe, minutes=12, seconds=34, frame_valid=1, digits=16'h1234.
- Same scan, then insert a 2-cycle glitch (anode 1110/cath 0000000) with SETTLE_CYCLES=4 -> no capture, d0 stays 4, no extra seen bit.
- Scan with d2 cathode 1111111 -> blank=4'b0100, frame_valid=0, minutes/seconds hold prior 12/34, frame_strobe still pulses.
- Drive anode 0011 and anode 1111 for 100 cycles each -> no captures, seen unchanged; cathode 1010101 on anode 1110 -> invalid[0]=1.
- TIMEOUT_CYCLES=64, stop scanning after two digits -> stale=1 at 64 cycles after the last capture, seen cleared; a full scan then yields a strobe and stale=0.
- Assert rst mid-frame after three captures -> all outputs at reset values asynchronously; a following full scan of 05:59 -> minutes=5, seconds=59 on the first strobe.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - decodes a multiplexed 4-digit seven-segment scan back into BCD digits and mm:ss
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   anode_vec[3:0]      active-low digit enables ([3]=min tens .. [0]=sec ones)
//   cathode_vec[6:0]    active-low segments (bit0=a .. bit6=g)
//   digits[15:0]        last captured BCD per position {d3,d2,d1,d0}
//   blank[3:0]          last capture at that position had all segments off
//   invalid[3:0]        last capture at that position was not a digit and not blank
//   minutes, seconds    values from the most recent valid frame
//   frame_strobe        one-cycle pulse when all four positions have been captured
//   frame_valid         quality of the most recent frame
//   stale               no capture for TIMEOUT_CYCLES clocks
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TO_W           = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  anode_vec,
    input  logic [6:0]  cathode_vec,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [3:0]  invalid,
    output logic [5:0]  minutes,
    output logic [5:0]  seconds,
    output logic        frame_strobe,
    output logic        frame_valid,
    output logic        stale
);
    localparam int SC_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_FIRE = SC_W'(SETTLE_CYCLES - 2);
    localparam logic [SC_W-1:0] SC_SAT  = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

    logic [3:0]      anode_s1_q, anode_s1_d, anode_s2_q, anode_s2_d;
    logic [6:0]      cath_s1_q, cath_s1_d, cath_s2_q, cath_s2_d;
    logic [10:0]     pair_prev_q, pair_prev_d;
    logic [SC_W-1:0] settle_cnt_q, settle_cnt_d;
    logic            armed_q, armed_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]      seen_q, seen_d;
    logic [15:0]     digits_q, digits_d;
    logic [3:0]      blank_q, blank_d, invalid_q, invalid_d;
    logic [5:0]      minutes_q, minutes_d, seconds_q, seconds_d;
    logic            frame_strobe_q, frame_strobe_d;
    logic            frame_valid_q, frame_valid_d;
    logic            stale_q, stale_d;

    logic       same, fire, one_low, capture, fv;
    logic [1:0] cap_pos;
    logic [3:0] dec_digit, d3, d2, d1, d0;
    logic       dec_blank, dec_inv;

    // Segment pattern to BCD (patterns listed g..a, active-low).
    always_comb begin
        dec_digit = 4'd0;
        dec_blank = 1'b0;
        dec_inv   = 1'b0;
        case (cath_s2_q)
            7'b1000000: dec_digit = 4'd0;
            7'b1111001: dec_digit = 4'd1;
            7'b0100100: dec_digit = 4'd2;
            7'b0110000: dec_digit = 4'd3;
            7'b0011001: dec_digit = 4'd4;
            7'b0010010: dec_digit = 4'd5;
            7'b0000010: dec_digit = 4'd6;
            7'b1111000: dec_digit = 4'd7;
            7'b0000000: dec_digit = 4'd8;
            7'b0010000: dec_digit = 4'd9;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_inv   = 1'b1;
        endcase
    end

    // Only a single low anode addresses a position; idle and overlap never do.
    always_comb begin
        cap_pos = 2'd0;
        one_low = 1'b1;
        case (anode_s2_q)
            4'b1110: cap_pos = 2'd0;
            4'b1101: cap_pos = 2'd1;
            4'b1011: cap_pos = 2'd2;
            4'b0111: cap_pos = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    assign d3 = digits_q[15:12];
    assign d2 = digits_q[11:8];
    assign d1 = digits_q[7:4];
    assign d0 = digits_q[3:0];

    assign same = ({anode_s2_q, cath_s2_q} == pair_prev_q);
    // settle_cnt counts repeat cycles, so SC_FIRE is reached on the
    // SETTLE_CYCLES-th cycle the pair is present; armed blocks refiring.
    assign fire    = same && !armed_q && (settle_cnt_q == SC_FIRE);
    assign capture = fire && one_low;
    assign fv      = (blank_q == 4'd0) && (invalid_q == 4'd0) && (d3 <= 4'd5) && (d1 <= 4'd5);

    always_comb begin
        anode_s1_d     = anode_vec;
        anode_s2_d     = anode_s1_q;
        cath_s1_d      = cathode_vec;
        cath_s2_d      = cath_s1_q;
        pair_prev_d    = {anode_s2_q, cath_s2_q};
        settle_cnt_d   = settle_cnt_q;
        armed_d        = armed_q;
        to_cnt_d       = to_cnt_q;
        seen_d         = seen_q;
        digits_d       = digits_q;
        blank_d        = blank_q;
        invalid_d      = invalid_q;
        minutes_d      = minutes_q;
        seconds_d      = seconds_q;
        frame_strobe_d = 1'b0;
        frame_valid_d  = frame_valid_q;
        stale_d        = stale_q;

        if (!same) begin
            settle_cnt_d = '0;
            armed_d      = 1'b0;
        end else if (settle_cnt_q != SC_SAT) begin
            settle_cnt_d = settle_cnt_q + SC_W'(1);
        end
        if (fire) begin
            armed_d = 1'b1;
        end

        // Timeout: a capture always wins over the terminal count.
        if (capture) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (to_cnt_q == TO_MAX - TO_W'(1)) begin
                stale_d = 1'b1;
                seen_d  = 4'd0;
            end
        end

        if (seen_q == 4'hF) begin
            frame_strobe_d = 1'b1;
            seen_d         = 4'd0;
            stale_d        = 1'b0;
            frame_valid_d  = fv;
            if (fv) begin
                minutes_d = {2'b00, d3} * 6'd10 + {2'b00, d2};
                seconds_d = {2'b00, d1} * 6'd10 + {2'b00, d0};
            end
        end

        if (capture) begin
            seen_d[cap_pos]           = 1'b1;
            digits_d[cap_pos*4 +: 4]  = dec_digit;
            blank_d[cap_pos]          = dec_blank;
            invalid_d[cap_pos]        = dec_inv;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode_s1_q     <= 4'hF;
            anode_s2_q     <= 4'hF;
            cath_s1_q      <= 7'h7F;
            cath_s2_q      <= 7'h7F;
            pair_prev_q    <= 11'h7FF;
            settle_cnt_q   <= '0;
            armed_q        <= 1'b0;
            to_cnt_q       <= '0;
            seen_q         <= 4'd0;
            digits_q       <= 16'd0;
            blank_q        <= 4'hF;
            invalid_q      <= 4'd0;
            minutes_q      <= 6'd0;
            seconds_q      <= 6'd0;
            frame_strobe_q <= 1'b0;
            frame_valid_q  <= 1'b0;
            stale_q        <= 1'b0;
        end else begin
            anode_s1_q     <= anode_s1_d;
            anode_s2_q     <= anode_s2_d;
            cath_s1_q      <= cath_s1_d;
            cath_s2_q      <= cath_s2_d;
            pair_prev_q    <= pair_prev_d;
            settle_cnt_q   <= settle_cnt_d;
            armed_q        <= armed_d;
            to_cnt_q       <= to_cnt_d;
            seen_q         <= seen_d;
            digits_q       <= digits_d;
            blank_q        <= blank_d;
            invalid_q      <= invalid_d;
            minutes_q      <= minutes_d;
            seconds_q      <= seconds_d;
            frame_strobe_q <= frame_strobe_d;
            frame_valid_q  <= frame_valid_d;
            stale_q        <= stale_d;
        end
    end

    assign digits       = digits_q;
    assign blank        = blank_q;
    assign invalid      = invalid_q;
    assign minutes      = minutes_q;
    assign seconds      = seconds_q;
    assign frame_strobe = frame_strobe_q;
    assign frame_valid  = frame_valid_q;
    assign stale        = stale_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder with a digit-level reference model
module tb_seg_scan_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  anode_vec = 4'hF;
    logic [6:0]  cathode_vec = 7'h7F;
    logic [15:0] digits;
    logic [3:0]  blank, invalid;
    logic [5:0]  minutes, seconds;
    logic        frame_strobe, frame_valid, stale;

    seg_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64), .TO_W(7)) dut (
        .clk(clk), .rst(rst), .anode_vec(anode_vec), .cathode_vec(cathode_vec),
        .digits(digits), .blank(blank), .invalid(invalid), .minutes(minutes),
        .seconds(seconds), .frame_strobe(frame_strobe), .frame_valid(frame_valid),
        .stale(stale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  mn;
        logic [5:0]  sc;
        logic        fv;
        logic [15:0] dg;
        logic [3:0]  bl;
        logic [3:0]  iv;
    } frame_t;

    frame_t     exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [6:0] seg [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference model: what the display currently shows, per position.
    logic [3:0] mdig [4];
    logic [3:0] mblank, minv, mseen;
    int         mmin, msec;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) mdig[i] = 4'd0;
        mblank = 4'hF;
        minv   = 4'h0;
        mseen  = 4'h0;
        mmin   = 0;
        msec   = 0;
    endfunction

    function automatic void model_capture(int pos, logic [6:0] c);
        int     d = -1;
        frame_t f;
        for (int i = 0; i < 10; i++) if (seg[i] == c) d = i;
        mdig[pos]   = (d < 0) ? 4'd0 : 4'(d);
        mblank[pos] = (c == 7'h7F);
        minv[pos]   = (d < 0) && (c != 7'h7F);
        mseen[pos]  = 1'b1;
        if (mseen == 4'hF) begin
            mseen = 4'h0;
            f.fv  = (mblank == 0) && (minv == 0) && (mdig[3] <= 5) && (mdig[1] <= 5);
            if (f.fv) begin
                mmin = mdig[3] * 10 + mdig[2];
                msec = mdig[1] * 10 + mdig[0];
            end
            f.mn = 6'(mmin);
            f.sc = 6'(msec);
            f.dg = {mdig[3], mdig[2], mdig[1], mdig[0]};
            f.bl = mblank;
            f.iv = minv;
            exp_q.push_back(f);
        end
    endfunction

    task automatic drive(logic [3:0] a, logic [6:0] c, int n);
        anode_vec   = a;
        cathode_vec = c;
        repeat (n) @(posedge clk);
    endtask

    // Expectation is recorded before the stimulus so the monitor never races it.
    task automatic show(int pos, logic [6:0] c);
        logic [3:0] a = 4'hF;
        a[pos] = 1'b0;
        model_capture(pos, c);
        drive(a, c, 10);
        drive(4'hF, 7'h7F, 3);
    endtask

    task automatic scan(logic [6:0] c3, logic [6:0] c2, logic [6:0] c1, logic [6:0] c0);
        show(3, c3);
        show(2, c2);
        show(1, c1);
        show(0, c0);
    endtask

    task automatic check_state(string tag);
        #1;
        chk({tag, "_digits"}, 32'(digits), 32'({mdig[3], mdig[2], mdig[1], mdig[0]}));
        chk({tag, "_blank"}, 32'(blank), 32'(mblank));
        chk({tag, "_invalid"}, 32'(invalid), 32'(minv));
    endtask

    function automatic logic [6:0] rand_cath();
        int         r = int'($urandom_range(0, 9));
        logic [6:0] c;
        bit         hit;
        if (r == 0) return 7'h7F;
        if (r == 1) begin
            do begin
                c   = 7'($urandom);
                hit = (c == 7'h7F);
                for (int i = 0; i < 10; i++) if (seg[i] == c) hit = 1'b1;
            end while (hit);
            return c;
        end
        return seg[$urandom_range(0, 9)];
    endfunction

    always @(negedge clk) begin
        frame_t e;
        if (rst && frame_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=1 expected=0 minutes=%0d seconds=%0d", minutes, seconds);
            end else begin
                e = exp_q.pop_front();
                chk("frame_minutes", 32'(minutes), 32'(e.mn));
                chk("frame_seconds", 32'(seconds), 32'(e.sc));
                chk("frame_valid", 32'(frame_valid), 32'(e.fv));
                chk("frame_digits", 32'(digits), 32'(e.dg));
                chk("frame_blank", 32'(blank), 32'(e.bl));
                chk("frame_invalid", 32'(invalid), 32'(e.iv));
            end
        end
    end

    initial begin
        int  perm [4];
        int  tmp, j, waited;
        bit  got;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits", 32'(digits), 0);
        chk("rst_blank", 32'(blank), 32'hF);
        chk("rst_invalid", 32'(invalid), 0);
        chk("rst_min_sec", 32'({minutes, seconds}), 0);
        chk("rst_flags", 32'({frame_strobe, frame_valid, stale}), 0);
        @(negedge clk);
        rst = 1'b1;

        // 12:34 then a 2-cycle glitch on position 0 that must not capture.
        scan(seg[1], seg[2], seg[3], seg[4]);
        check_state("scan1234");
        drive(4'hE, 7'h00, 2);
        drive(4'hF, 7'h7F, 10);
        check_state("glitch");
        scan(seg[1], seg[2], seg[3], seg[4]);

        // Blank middle digit: strobe, invalid frame, previous mm:ss held.
        scan(seg[1], 7'h7F, seg[3], seg[4]);
        check_state("blank");

        // Overlapping and idle anodes never capture.
        drive(4'h3, seg[8], 100);
        drive(4'hF, 7'h7F, 100);
        check_state("no_capture");
        show(0, 7'h55);
        check_state("invalid0");
        show(3, seg[1]);
        show(2, seg[2]);
        show(1, seg[3]);

        // Timeout after two digits.
        show(3, seg[1]);
        show(2, seg[2]);
        repeat (40) @(posedge clk);
        #1;
        chk("stale_not_early", 32'(stale), 0);
        got = 1'b0;
        waited = 0;
        while (!got && waited < 60) begin
            @(posedge clk);
            #1;
            got = stale;
            waited++;
        end
        chk("stale_raised", 32'(got), 1);
        for (int i = 0; i < 4; i++) mseen[i] = 1'b0;
        show(1, seg[3]);
        show(0, seg[4]);
        scan(seg[1], seg[2], seg[3], seg[4]);
        #1;
        chk("stale_cleared", 32'(stale), 0);

        // Asynchronous reset in the middle of a frame.
        show(3, seg[0]);
        show(2, seg[5]);
        show(1, seg[5]);
        drive(4'hE, seg[9], 4);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_digits", 32'(digits), 0);
        chk("async_rst_blank", 32'(blank), 32'hF);
        chk("async_rst_min_sec", 32'({minutes, seconds}), 0);
        chk("async_rst_flags", 32'({frame_strobe, frame_valid, stale, invalid}), 0);
        drive(4'hF, 7'h7F, 3);
        @(negedge clk);
        rst = 1'b1;
        scan(seg[0], seg[5], seg[5], seg[9]);

        // Random frames in random order, with occasional recapture.
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < 4; i++) perm[i] = i;
            for (int i = 3; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                tmp = perm[i];
                perm[i] = perm[j];
                perm[j] = tmp;
            end
            for (int i = 0; i < 4; i++) begin
                if (i == 3 && $urandom_range(0, 2) == 0)
                    show(perm[$urandom_range(0, 2)], rand_cath());
                if (perm[i] == 3 || perm[i] == 1)
                    show(perm[i], $urandom_range(0, 3) == 0 ? rand_cath() : seg[$urandom_range(0, 6)]);
                else
                    show(perm[i], $urandom_range(0, 3) == 0 ? rand_cath() : seg[$urandom_range(0, 9)]);
            end
        end

        drive(4'hF, 7'h7F, 20);
        check_state("final");
        chk("all_frames_seen", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
